// File: rtl/findmax_seq.sv
// Read sequencer for the find-max datapath: issues n sequential memory reads and
// tags each returning sample with valid/first/last, aligned to the memory read latency.
module findmax_seq #(
    parameter int ADDR_W = 8,
    parameter int N_W    = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       start_addr,
    input  logic [N_W-1:0]    n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              data_valid,
    output logic              data_first,
    output logic              data_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [N_W:0]      CNT_ONE  = (N_W + 1)'(1);
    localparam logic [N_W-1:0]    N_ONE    = N_W'(1);

    state_t            state;
    logic [N_W:0]      cnt;
    logic [N_W:0]      next_cnt;
    logic [N_W-1:0]    n_lat;
    logic              first_p0;
    logic              last_p0;
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] first_p;
    logic [RD_LAT-1:0] last_p;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_ONE;
    endfunction

    generate
        if (ADDR_W < 16) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^start_addr[15:ADDR_W];
        end
    endgenerate

    // cnt counts elements already issued; one extra bit keeps n = 2^N_W-1 exact
    assign next_cnt = cnt + CNT_ONE;

    // Stage p0: issue control, address generation and first/last tags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            n_lat    <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_en <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        n_lat <= n;
                        busy  <= 1'b1;
                        if (n == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            mem_en   <= 1'b1;
                            mem_addr <= start_addr[ADDR_W-1:0];
                            cnt      <= CNT_ONE;
                            first_p0 <= 1'b1;
                            last_p0  <= (n == N_ONE);
                        end
                    end
                end
                ISSUE: begin
                    first_p0 <= 1'b0;
                    if (cnt == {1'b0, n_lat}) begin
                        state   <= DRAIN;
                        mem_en  <= 1'b0;
                        last_p0 <= 1'b0;
                    end else begin
                        mem_en   <= 1'b1;
                        mem_addr <= addr_inc(mem_addr);
                        cnt      <= next_cnt;
                        last_p0  <= (next_cnt == {1'b0, n_lat});
                    end
                end
                DRAIN: begin
                    if (data_valid && data_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1..pRD_LAT: sample tags follow mem_en through the read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
        end else begin
            vld_p[0]   <= mem_en;
            first_p[0] <= mem_en & first_p0;
            last_p[0]  <= mem_en & last_p0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                first_p[i] <= first_p[i-1];
                last_p[i]  <= last_p[i-1];
            end
        end
    end

    assign data_valid = vld_p[RD_LAT-1];
    assign data_first = first_p[RD_LAT-1];
    assign data_last  = last_p[RD_LAT-1];

endmodule

// File: tb/tb_findmax_seq.sv
// Directed bench for findmax_seq: per-cycle vector table plus hand sequences
// for mid-run reset and a deeper read latency with start held high.
module tb_findmax_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start3;
    logic [15:0] start_addr, start_addr3;
    logic [7:0]  n, n3;

    logic [7:0]  mem_addr, mem_addr3;
    logic        mem_en, data_valid, data_first, data_last, busy, done;
    logic        mem_en3, data_valid3, data_first3, data_last3, busy3, done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    findmax_seq #(.ADDR_W(8), .N_W(8), .RD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .n(n),
        .mem_addr(mem_addr), .mem_en(mem_en), .data_valid(data_valid),
        .data_first(data_first), .data_last(data_last), .busy(busy), .done(done)
    );

    findmax_seq #(.ADDR_W(8), .N_W(8), .RD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .start_addr(start_addr3), .n(n3),
        .mem_addr(mem_addr3), .mem_en(mem_en3), .data_valid(data_valid3),
        .data_first(data_first3), .data_last(data_last3), .busy(busy3), .done(done3)
    );

    typedef struct {
        logic        st;
        logic [15:0] sa;
        logic [7:0]  nn;
        logic        en;
        logic [7:0]  a;
        logic        v, f, l, b, d;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input int st, input int sa, input int nn, input int en,
                                input int a, input int v, input int f, input int l,
                                input int b, input int d);
        vec_t r;
        r.st = (st != 0);
        r.sa = 16'(sa);
        r.nn = 8'(nn);
        r.en = (en != 0);
        r.a  = 8'(a);
        r.v  = (v != 0);
        r.f  = (f != 0);
        r.l  = (l != 0);
        r.b  = (b != 0);
        r.d  = (d != 0);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // advance one clock and compare every u1 output against the expected values
    task automatic step_chk(input string tag, input logic en, input logic [7:0] a,
                            input logic v, input logic f, input logic l,
                            input logic b, input logic d);
        @(posedge clk);
        #1;
        chk({tag, ".mem_en"},     32'(mem_en),     32'(en));
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'(a));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(v));
        chk({tag, ".data_first"}, 32'(data_first), 32'(f));
        chk({tag, ".data_last"},  32'(data_last),  32'(l));
        chk({tag, ".busy"},       32'(busy),       32'(b));
        chk({tag, ".done"},       32'(done),       32'(d));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; start_addr = '0; n = '0;
        start3 = 1'b0; start_addr3 = '0; n3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.u1.outs", 32'({mem_addr, mem_en, data_valid, data_first, data_last, busy, done}), 0);
        chk("rst.u3.outs", 32'({mem_addr3, mem_en3, data_valid3, data_first3, data_last3, busy3, done3}), 0);
        reset = 1'b0;

        // entry k: inputs held during cycle k, expected outputs in cycle k+1
        //              st  sa     n  en  addr  v  f  l  b  d
        // n=5 from 0x10
        tv.push_back(mk(1, 'h10,  5, 1, 'h10, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 1, 'h11, 1, 1, 0, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 1, 'h12, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 1, 'h13, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 1, 'h14, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 0, 'h14, 1, 0, 1, 1, 0));
        tv.push_back(mk(0, 'h10,  5, 0, 'h14, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 'h10,  5, 0, 'h14, 0, 0, 0, 0, 0));
        // n=1
        tv.push_back(mk(1, 'h20,  1, 1, 'h20, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h20,  1, 0, 'h20, 1, 1, 1, 1, 0));
        tv.push_back(mk(0, 'h20,  1, 0, 'h20, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 'h20,  1, 0, 'h20, 0, 0, 0, 0, 0));
        // n=0: address holds, done+busy for one cycle
        tv.push_back(mk(1, 'h30,  0, 0, 'h20, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 'h30,  0, 0, 'h20, 0, 0, 0, 0, 0));
        // wrap from 0xFE; start pulses during ISSUE (cycle 3) and DONE (cycle 6) are ignored
        tv.push_back(mk(1, 'hFE,  4, 1, 'hFE, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 'hFE,  4, 1, 'hFF, 1, 1, 0, 1, 0));
        tv.push_back(mk(0, 'hFE,  4, 1, 'h00, 1, 0, 0, 1, 0));
        tv.push_back(mk(1, 'h55,  2, 1, 'h01, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 'h55,  2, 0, 'h01, 1, 0, 1, 1, 0));
        tv.push_back(mk(0, 'h55,  2, 0, 'h01, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 'h55,  2, 0, 'h01, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h55,  2, 0, 'h01, 0, 0, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            start      = tv[i].st;
            start_addr = tv[i].sa;
            n          = tv[i].nn;
            step_chk($sformatf("tbl%0d", i), tv[i].en, tv[i].a, tv[i].v, tv[i].f,
                     tv[i].l, tv[i].b, tv[i].d);
        end

        // reset in the middle of an n=6 run
        start = 1'b1; start_addr = 16'h0040; n = 8'd6;
        step_chk("rstrun.c1", 1, 8'h40, 0, 0, 0, 1, 0);
        start = 1'b0;
        step_chk("rstrun.c2", 1, 8'h41, 1, 1, 0, 1, 0);
        step_chk("rstrun.c3", 1, 8'h42, 1, 0, 0, 1, 0);
        reset = 1'b1;
        step_chk("rstrun.c4", 0, 8'h00, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstrun.quiet%0d", c),
                32'({mem_en, data_valid, busy, done}), 0);
        end
        start = 1'b1; start_addr = 16'h0040; n = 8'd2;
        step_chk("rerun.c1", 1, 8'h40, 0, 0, 0, 1, 0);
        start = 1'b0;
        step_chk("rerun.c2", 1, 8'h41, 1, 1, 0, 1, 0);
        step_chk("rerun.c3", 0, 8'h41, 1, 0, 1, 1, 0);
        step_chk("rerun.c4", 0, 8'h41, 0, 0, 0, 1, 1);
        step_chk("rerun.c5", 0, 8'h41, 0, 0, 0, 0, 0);

        // RD_LAT=3, n=3, start held high: second run begins issuing on cycle 9
        start3 = 1'b1; start_addr3 = 16'h0080; n3 = 8'd3;
        for (int c = 1; c <= 9; c++) begin
            logic [7:0] ea;
            @(posedge clk);
            #1;
            ea = (c == 9) ? 8'h80 : ((c <= 3) ? 8'(8'h80 + c - 1) : 8'h82);
            chk($sformatf("lat3.c%0d.mem_en", c),     32'(mem_en3),     32'((c <= 3) || (c == 9)));
            chk($sformatf("lat3.c%0d.mem_addr", c),   32'(mem_addr3),   32'(ea));
            chk($sformatf("lat3.c%0d.data_valid", c), 32'(data_valid3), 32'((c >= 4) && (c <= 6)));
            chk($sformatf("lat3.c%0d.data_first", c), 32'(data_first3), 32'(c == 4));
            chk($sformatf("lat3.c%0d.data_last", c),  32'(data_last3),  32'(c == 6));
            chk($sformatf("lat3.c%0d.busy", c),       32'(busy3),       32'((c <= 7) || (c == 9)));
            chk($sformatf("lat3.c%0d.done", c),       32'(done3),       32'(c == 7));
        end
        start3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
